// File: rtl/sorter_seq.sv
// sorter_seq: serial-in/serial-out batch sorter, odd-even transposition with one phase per clock.
// Outputs decode from registered state only, so ready/valid never depend combinationally on the peer.
module sorter_seq #(
    parameter int N     = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             desc,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);
    localparam int IW = $clog2(N);
    localparam int PW = IW + 1;

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    phase;
    logic             ord;
    logic [WIDTH-1:0] mem    [N];
    logic [WIDTH-1:0] sorted [N];
    logic             in_fire, out_fire, idx_end, phase_end;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign idx_end   = idx == IW'(N - 1);
    assign phase_end = phase == PW'(N - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = (in_fire && idx_end) ? SORT : LOAD;
            SORT:    state_nxt = phase_end ? DRAIN : SORT;
            DRAIN:   state_nxt = (out_fire && idx_end) ? LOAD : DRAIN;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = state == LOAD;
        out_valid = state == DRAIN;
        busy      = state != LOAD;
        out_last  = out_valid && idx_end;
        out_data  = out_valid ? mem[idx] : '0;
    end

    // Pairs start at even indices on even phases, odd indices on odd phases; pairs never overlap.
    always_comb begin
        sorted = mem;
        for (int i = 0; i < N - 1; i++) begin
            if ((i[0] == phase[0]) && (ord ? mem[i] < mem[i+1] : mem[i] > mem[i+1])) begin
                sorted[i]   = mem[i+1];
                sorted[i+1] = mem[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            idx   <= '0;
            phase <= '0;
            ord   <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_fire) begin
                    mem[idx] <= in_data;
                    if (idx == '0) ord <= desc;
                    idx   <= idx_end ? '0 : idx + 1'b1;
                    phase <= '0;
                end
                SORT: begin
                    mem   <= sorted;
                    phase <= phase + 1'b1;
                    idx   <= '0;
                end
                DRAIN: if (out_fire) idx <= idx_end ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/sorter_seq.md
# sorter_seq

Parametrised, sequential successor to the combinational eight-input sorter. It collects a batch of N words serially through a valid/ready input port and sorts them in place with odd-even transposition, one compare-exchange phase per clock. The sorted batch then streams out through a valid/ready output port in ascending or descending order, selectable per batch. It sits between a streaming producer and consumer that previously needed all eight operands presented in parallel.

## Interface
- N, 8, words per batch; even, 2 ≤ N ≤ 64
- WIDTH, 8, bits per word (unsigned)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- desc  in  1  order select: 0 = ascending, 1 = descending; sampled with the first word of each batch
- in_valid  in  1  input word valid
- in_data  in  WIDTH  input word
- in_ready  out  1  block accepts a word this cycle
- out_valid  out  1  output word valid
- out_data  out  WIDTH  output word
- out_ready  in  1  consumer accepts a word this cycle
- out_last  out  1  marks the final word of a batch, qualified by out_valid
- busy  out  1  high in SORT and DRAIN

## Operation
- Storage: N×WIDTH register array buf[0..N-1], counter idx of $clog2(N) bits, phase counter of $clog2(N)+1 bits, latched order bit ord.
- FSM states LOAD, SORT, DRAIN; reset state is LOAD.
- LOAD: in_ready=1. Each handshake (in_valid&in_ready) writes buf[idx] and increments idx.
  - On the first handshake of a batch (idx=0), ord←desc.
  - On the handshake with idx=N-1: idx←0, phase←0, state←SORT.
- SORT: in_ready=0, out_valid=0, busy=1. There is exactly one phase per cycle, N phases in total.
  - Even phase compares pairs (0,1),(2,3),…,(N-2,N-1).
  - Odd phase compares pairs (1,2),…,(N-3,N-2).
  - Ascending: swap when buf[i] > buf[i+1]. Descending: swap when buf[i] < buf[i+1].
  - Equal words never swap.
  - After phase N-1: state←DRAIN, idx←0.
- DRAIN: out_valid=1, out_data=buf[idx], out_last=(idx==N-1).
  - Each handshake increments idx.
  - The handshake with idx=N-1 sets idx←0 and state←LOAD.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Comparisons are unsigned over the full WIDTH. No arithmetic widening is needed.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.
- desc changes mid-batch have no effect. Only the value latched into ord is used.

## Timing
- Reset (rst_n=0 at a rising edge) forces these values on the next cycle:
  - state=LOAD, idx=0, phase=0, ord=0, all buf words=0;
  - out_valid=0, out_last=0, busy=0, out_data=0, in_ready=1.
- Reset has priority over any handshake in the same cycle. Reset mid-batch or mid-drain discards the partial batch; no word is emitted.
- in_ready, out_valid, out_last and busy decode combinationally from the registered state only. There is no combinational path from in_valid or out_ready to any output.
- Latency: last input handshake at edge k → SORT during cycles k+1…k+N → first out_valid in cycle k+N+1.
- With in_valid and out_ready held high, one batch takes 3N cycles: N load, N sort, N drain.
- Throughput: one word per cycle in LOAD and DRAIN. No overlap between batches; in_ready=0 from the edge after the last input until the edge after the last output.
- Back-to-back: the cycle after the final output handshake is LOAD with in_ready=1.

## Test plan
- Ascending sort:
  - Stimulus: N=8, WIDTH=8, desc=0, inputs 7,6,5,4,3,2,1,0 with in_valid held high.
  - Response: out 0…7 in order; out_last only on 7; first out_valid exactly 9 cycles after the last input handshake.
- Descending with duplicates:
  - Stimulus: desc=1 on the first word (toggled to 0 afterwards), inputs 3,255,0,3,128,255,1,0.
  - Response: out 255,255,128,3,3,1,0,0.
- Backpressure and input gaps:
  - Stimulus: in_valid deasserted on every other cycle; out_ready random with 50% duty.
  - Response: correct sorted order; out_data stable while stalled; exactly N output handshakes; in_ready stays 0 until after out_last.
- Reset during operation:
  - Stimulus: rst_n=0 for one cycle during SORT phase 3, then a fresh batch 10,20,…,80 in descending-input order.
  - Response: all outputs at reset values the cycle after reset; old data never emitted; new batch emerges as 10…80.
- Parameter sweep:
  - Stimulus: N=4, WIDTH=16, inputs 0xFFFF,0x0001,0x8000,0x0000 in both modes.
  - Response: ascending gives 0x0000,0x0001,0x8000,0xFFFF; descending gives the reverse.
- Back-to-back batches:
  - Stimulus: two random batches with in_valid and out_ready held high.
  - Response: each batch matches a reference model sort; the second batch's first word is accepted the cycle after the first batch's out_last handshake.
